btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
Sequences training writes into the branch target buffer's single update port. Two branch-resolution requesters can report a mispredict in the same cycle. The block arbitrates between them, coalesces updates to the same PC, buffers them in a small FIFO and drains at most one update per cycle into the BTB update interface. Training is best-effort: requests that do not fit are dropped and counted, and are never back-pressured into the pipeline.

Parameters:
QDEPTH, 4, queue entries; power of two, >= 2
CNTW, 16, width of the saturating drop counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req0_valid  in  1  mispredict report from the older branch unit
req0_pc  in  32  PC of the older branch
req0_target  in  32  resolved target of the older branch
req0_ins_type  in  3  instruction type of the older branch
req1_valid  in  1  mispredict report from the younger branch unit
req1_pc  in  32  PC of the younger branch
req1_target  in  32  resolved target of the younger branch
req1_ins_type  in  3  instruction type of the younger branch
hold  in  1  suppress issue this cycle; enqueue still allowed
flush  in  1  discard all queued and incoming updates
req_ready  out  1  queue can accept two requests this cycle
branch_mistaken  out  1  BTB update strobe, registered
wrong_pc  out  32  BTB update PC, registered
right_target  out  32  BTB update target, registered
ins_type_w  out  3  BTB update type, registered
q_count  out  $clog2(QDEPTH)+1  occupied entries
drop_cnt  out  CNTW  saturating count of dropped requests

Behaviour:
- Reset: queue empty; head and tail pointers 0; all outputs 0; drop_cnt 0.
- req_ready is combinational: (QDEPTH - q_count) >= 2, using the start-of-cycle count. A pop in the same cycle does not add capacity.
- PC matching compares pc[31:2] only.
- Acceptance when req_ready=1 and flush=0:
  - req0 is processed before req1.
  - If req0 and req1 are both valid with matching PCs, only req1 is processed (younger wins).
  - If an incoming request matches a queued entry that is not being popped this cycle, that entry's target and ins_type are overwritten in place. No allocation.
  - If it matches only the entry popped this cycle, or matches nothing, a new entry is allocated at the tail.
  - At most two allocations per cycle.
- Drops: when req_ready=0 and flush=0, every valid request is discarded. drop_cnt increments by the number discarded (0, 1 or 2) and saturates at all-ones.
- Issue:
  - Each cycle with q_count != 0, hold=0 and flush=0, the head is popped.
  - On the next edge: branch_mistaken <= 1 and wrong_pc/right_target/ins_type_w <= the head fields.
  - Otherwise branch_mistaken <= 0 and the data outputs hold their last value.
  - branch_mistaken is a single-cycle pulse per entry; back-to-back pops give consecutive pulses.
- Latency: a request accepted in cycle N, with an empty queue and hold=0, produces its branch_mistaken pulse in cycle N+2.
- Count: q_count next = q_count + allocations - pop. It never exceeds QDEPTH. Pointers wrap modulo QDEPTH.
- Flush has highest priority:
  - Next cycle q_count = 0, pointers are reset and branch_mistaken = 0.
  - Incoming requests in the flush cycle are discarded and not counted in drop_cnt.
  - A pulse already registered in the flush cycle still appears; flush acts on the following edge only.
- hold=1 with flush=0: no pop, branch_mistaken <= 0; enqueue, coalescing and drops proceed normally.
- Reset asserted mid-drain: next cycle all outputs are 0 and queued entries are lost.

Test Plan:
- Single request, single pulse: req0 {pc 0x1c000100, target 0x1c000200, type 3'b001} in cycle 0 on an empty queue. Required: branch_mistaken=1 only in cycle 2 with those values; q_count 1 in cycle 1, 0 in cycle 2.
- Dual request, ordering: req0 pc 0x1c000100 and req1 pc 0x1c000180, same cycle. Required: pulses in cycles 2 and 3, req0 first; q_count peaks at 2.
- Same-cycle coalescing: req0 and req1 both pc 0x1c000104, targets 0x1c001000 and 0x1c002000. Required: one pulse, right_target=0x1c002000, q_count peaks at 1.
- In-queue coalescing: hold=1; push pc 0x1c000040 with target 0x1c000800, then the same pc with target 0x1c000900. Required: q_count stays 1. After hold drops, one pulse with 0x1c000900.
- Overflow and drops (QDEPTH=4, hold=1): push distinct PCs until q_count=3. Required: req_ready=0 at q_count=3. A further dual request leaves q_count=3 and drop_cnt=2. Releasing hold gives 3 consecutive pulses; req_ready returns to 1 once q_count<=2.
- Flush and reset: with 2 entries queued, assert flush together with a valid req0. Required: q_count=0 next cycle, no pulses, drop_cnt unchanged. Separately, reset during a draining burst forces branch_mistaken=0, q_count=0, drop_cnt=0 next cycle.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// BTB training-update sequencer: arbitrates two mispredict reports, coalesces them by PC,
// buffers them in a small circular queue and drains one registered BTB update per cycle.
module btb_update_ctrl #(
    parameter int QDEPTH = 4,
    parameter int CNTW   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_valid,
    input  logic [31:0]             req0_pc,
    input  logic [31:0]             req0_target,
    input  logic [2:0]              req0_ins_type,
    input  logic                    req1_valid,
    input  logic [31:0]             req1_pc,
    input  logic [31:0]             req1_target,
    input  logic [2:0]              req1_ins_type,
    input  logic                    hold,
    input  logic                    flush,
    output logic                    req_ready,
    output logic                    branch_mistaken,
    output logic [31:0]             wrong_pc,
    output logic [31:0]             right_target,
    output logic [2:0]              ins_type_w,
    output logic [$clog2(QDEPTH):0] q_count,
    output logic [CNTW-1:0]         drop_cnt
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int DW = CNTW + 1;

    logic [31:0]     pc_q   [QDEPTH];
    logic [31:0]     pc_d   [QDEPTH];
    logic [31:0]     tgt_q  [QDEPTH];
    logic [31:0]     tgt_d  [QDEPTH];
    logic [2:0]      typ_q  [QDEPTH];
    logic [2:0]      typ_d  [QDEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CNTW-1:0] drop_q, drop_d;
    logic            bm_q, bm_d;
    logic [31:0]     wpc_q, wpc_d;
    logic [31:0]     rtgt_q, rtgt_d;
    logic [2:0]      wtyp_q, wtyp_d;

    logic            pop;
    logic            take0;
    logic            hit0, hit1;
    logic [PW-1:0]   idx0, idx1;
    logic [PW-1:0]   off;
    logic [PW-1:0]   wptr;
    logic [CW-1:0]   n_alloc;
    logic [1:0]      n_drop;
    logic [DW-1:0]   drop_sum;

    // Capacity is judged on the start-of-cycle count; a same-cycle pop frees nothing.
    assign req_ready = (CW'(QDEPTH) - count_q) >= CW'(2);

    always_comb begin
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        typ_d    = typ_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        drop_d   = drop_q;
        bm_d     = 1'b0;
        wpc_d    = wpc_q;
        rtgt_d   = rtgt_q;
        wtyp_d   = wtyp_q;
        pop      = (count_q != '0) && !hold && !flush;
        take0    = req0_valid && !(req1_valid && (req0_pc[31:2] == req1_pc[31:2]));
        hit0     = 1'b0;
        hit1     = 1'b0;
        idx0     = '0;
        idx1     = '0;
        off      = '0;
        wptr     = tail_q;
        n_alloc  = '0;
        n_drop   = '0;
        drop_sum = '0;

        // The head leaving this cycle is not a coalescing target; a match there allocates anew.
        for (int i = 0; i < QDEPTH; i++) begin
            off = PW'(i) - head_q;
            if ((CW'(off) < count_q) && !(pop && (off == '0))) begin
                if (!hit0 && (pc_q[i][31:2] == req0_pc[31:2])) begin
                    hit0 = 1'b1;
                    idx0 = PW'(i);
                end
                if (!hit1 && (pc_q[i][31:2] == req1_pc[31:2])) begin
                    hit1 = 1'b1;
                    idx1 = PW'(i);
                end
            end
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (req_ready) begin
                if (take0) begin
                    if (hit0) begin
                        tgt_d[idx0] = req0_target;
                        typ_d[idx0] = req0_ins_type;
                    end else begin
                        pc_d[wptr]  = req0_pc;
                        tgt_d[wptr] = req0_target;
                        typ_d[wptr] = req0_ins_type;
                        wptr        = wptr + 1'b1;
                        n_alloc     = n_alloc + 1'b1;
                    end
                end
                if (req1_valid) begin
                    if (hit1) begin
                        tgt_d[idx1] = req1_target;
                        typ_d[idx1] = req1_ins_type;
                    end else begin
                        pc_d[wptr]  = req1_pc;
                        tgt_d[wptr] = req1_target;
                        typ_d[wptr] = req1_ins_type;
                        wptr        = wptr + 1'b1;
                        n_alloc     = n_alloc + 1'b1;
                    end
                end
            end else begin
                n_drop   = {1'b0, req0_valid} + {1'b0, req1_valid};
                drop_sum = {1'b0, drop_q} + DW'(n_drop);
                drop_d   = drop_sum[CNTW] ? '1 : drop_sum[CNTW-1:0];
            end

            if (pop) begin
                bm_d   = 1'b1;
                wpc_d  = pc_q[head_q];
                rtgt_d = tgt_q[head_q];
                wtyp_d = typ_q[head_q];
                head_d = head_q + 1'b1;
            end
            tail_d  = wptr;
            count_d = count_q + n_alloc - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                pc_q[i]  <= '0;
                tgt_q[i] <= '0;
                typ_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            bm_q    <= 1'b0;
            wpc_q   <= '0;
            rtgt_q  <= '0;
            wtyp_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            typ_q   <= typ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            bm_q    <= bm_d;
            wpc_q   <= wpc_d;
            rtgt_q  <= rtgt_d;
            wtyp_q  <= wtyp_d;
        end
    end

    assign branch_mistaken = bm_q;
    assign wrong_pc        = wpc_q;
    assign right_target    = rtgt_q;
    assign ins_type_w      = wtyp_q;
    assign q_count         = count_q;
    assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: directed scenarios then random traffic, checked
// against a queue-level reference model; a negedge monitor consumes expected BTB updates.
module tb_btb_update_ctrl;
    localparam int QDEPTH = 4;
    localparam int CNTW   = 5;
    localparam int DMAX   = (1 << CNTW) - 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [2:0]  ty;
    } ent_t;

    typedef struct packed {
        int   cyc;
        ent_t e;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0_valid, req1_valid;
    logic [31:0]     req0_pc, req0_target, req1_pc, req1_target;
    logic [2:0]      req0_ins_type, req1_ins_type;
    logic            hold, flush;
    logic            req_ready, branch_mistaken;
    logic [31:0]     wrong_pc, right_target;
    logic [2:0]      ins_type_w;
    logic [2:0]      q_count;
    logic [CNTW-1:0] drop_cnt;

    ent_t mq[$];
    exp_t exp_q[$];
    int   m_drops = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    logic started = 1'b0;
    logic reset_seen = 1'b0;
    logic exp_bm;
    exp_t cur;
    ent_t last = '0;

    btb_update_ctrl #(.QDEPTH(QDEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_pc(req0_pc), .req0_target(req0_target),
        .req0_ins_type(req0_ins_type),
        .req1_valid(req1_valid), .req1_pc(req1_pc), .req1_target(req1_target),
        .req1_ins_type(req1_ins_type),
        .hold(hold), .flush(flush), .req_ready(req_ready),
        .branch_mistaken(branch_mistaken), .wrong_pc(wrong_pc),
        .right_target(right_target), .ins_type_w(ins_type_w),
        .q_count(q_count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) reset_seen <= reset;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    // An update pulse is expected exactly in the cycle the model scheduled; otherwise data holds.
    always @(negedge clk) begin
        if (started) begin
            if (reset_seen) last = '0;
            exp_bm = 1'b0;
            if (exp_q.size() != 0) begin
                if (exp_q[0].cyc == cyc) exp_bm = 1'b1;
            end
            check("branch_mistaken", {31'd0, branch_mistaken}, {31'd0, exp_bm});
            if (exp_bm) begin
                cur  = exp_q.pop_front();
                last = cur.e;
            end
            check("wrong_pc", wrong_pc, last.pc);
            check("right_target", right_target, last.tgt);
            check("ins_type_w", {29'd0, ins_type_w}, {29'd0, last.ty});
        end
    end

    task automatic check_output();
        check("q_count", {29'd0, q_count}, mq.size());
        check("req_ready", {31'd0, req_ready}, {31'd0, (QDEPTH - mq.size()) >= 2});
        check("drop_cnt", {27'd0, drop_cnt}, m_drops);
    endtask

    task automatic model_insert(input ent_t r, input bit popping);
        int   hit;
        ent_t t;
        hit = -1;
        for (int j = 0; j < mq.size(); j++) begin
            if (hit < 0 && !(popping && j == 0) && mq[j].pc[31:2] == r.pc[31:2]) hit = j;
        end
        if (hit >= 0) begin
            t       = mq[hit];
            t.tgt   = r.tgt;
            t.ty    = r.ty;
            mq[hit] = t;
        end else begin
            mq.push_back(r);
        end
    endtask

    task automatic apply_stimulus(input bit rst, input bit h, input bit f,
                                  input bit v0, input logic [31:0] p0, input logic [31:0] t0,
                                  input logic [2:0] y0,
                                  input bit v1, input logic [31:0] p1, input logic [31:0] t1,
                                  input logic [2:0] y1);
        bit   rdy;
        bit   popping;
        ent_t hd;
        ent_t e0;
        ent_t e1;
        exp_t x;
        reset = rst; hold = h; flush = f;
        req0_valid = v0; req0_pc = p0; req0_target = t0; req0_ins_type = y0;
        req1_valid = v1; req1_pc = p1; req1_target = t1; req1_ins_type = y1;
        e0.pc = p0; e0.tgt = t0; e0.ty = y0;
        e1.pc = p1; e1.tgt = t1; e1.ty = y1;
        hd = '0;
        if (rst) begin
            mq.delete();
            m_drops = 0;
        end else if (f) begin
            mq.delete();
        end else begin
            rdy     = (QDEPTH - mq.size()) >= 2;
            popping = (mq.size() != 0) && !h;
            if (popping) hd = mq[0];
            if (rdy) begin
                if (v0 && !(v1 && p0[31:2] == p1[31:2])) model_insert(e0, popping);
                if (v1) model_insert(e1, popping);
            end else begin
                m_drops += int'(v0) + int'(v1);
                if (m_drops > DMAX) m_drops = DMAX;
            end
            if (popping) begin
                void'(mq.pop_front());
                x.cyc = cyc + 1;
                x.e   = hd;
                exp_q.push_back(x);
            end
        end
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic idle(input bit h);
        apply_stimulus(0, h, 0, 0, '0, '0, '0, 0, '0, '0, '0);
    endtask

    task automatic one(input bit h, input logic [31:0] p, input logic [31:0] t, input logic [2:0] y);
        apply_stimulus(0, h, 0, 1, p, t, y, 0, '0, '0, '0);
    endtask

    task automatic two(input bit h, input logic [31:0] pa, input logic [31:0] ta,
                       input logic [31:0] pb, input logic [31:0] tb);
        apply_stimulus(0, h, 0, 1, pa, ta, 3'b010, 1, pb, tb, 3'b100);
    endtask

    initial begin
        bit          rr, hh, ff, v0, v1;
        logic [31:0] p0, p1, t0, t1;
        logic [2:0]  y0, y1;
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        req0_valid = 1'b0; req0_pc = '0; req0_target = '0; req0_ins_type = '0;
        req1_valid = 1'b0; req1_pc = '0; req1_target = '0; req1_ins_type = '0;
        @(posedge clk);
        #1;
        started = 1'b1;

        // single request: pulse two cycles after acceptance
        one(0, 32'h1c000100, 32'h1c000200, 3'b001);
        check("single_count_c1", {29'd0, q_count}, 1);
        idle(0);
        check("single_count_c2", {29'd0, q_count}, 0);
        idle(0);

        // dual request: req0 drains first
        two(0, 32'h1c000100, 32'h1c000a00, 32'h1c000180, 32'h1c000b00);
        check("dual_peak", {29'd0, q_count}, 2);
        idle(0); idle(0); idle(0);

        // same-cycle coalescing: younger target wins
        two(0, 32'h1c000104, 32'h1c001000, 32'h1c000104, 32'h1c002000);
        check("same_cycle_coalesce", {29'd0, q_count}, 1);
        idle(0); idle(0);

        // in-queue coalescing under hold
        one(1, 32'h1c000040, 32'h1c000800, 3'b011);
        one(1, 32'h1c000040, 32'h1c000900, 3'b101);
        check("inq_coalesce", {29'd0, q_count}, 1);
        idle(0); idle(0);

        // overflow and drops
        apply_stimulus(1, 0, 0, 0, '0, '0, '0, 0, '0, '0, '0);
        two(1, 32'h1c000010, 32'h1c000110, 32'h1c000020, 32'h1c000120);
        check("ovf_ready_at_2", {31'd0, req_ready}, 1);
        one(1, 32'h1c000030, 32'h1c000130, 3'b111);
        check("ovf_count_3", {29'd0, q_count}, 3);
        check("ovf_not_ready", {31'd0, req_ready}, 0);
        two(1, 32'h1c000050, 32'h1c000150, 32'h1c000060, 32'h1c000160);
        check("ovf_count_hold", {29'd0, q_count}, 3);
        check("ovf_drops", {27'd0, drop_cnt}, 2);
        idle(0);
        check("ovf_ready_again", {31'd0, req_ready}, 1);
        idle(0); idle(0); idle(0);

        // flush with queued entries and an incoming request
        two(1, 32'h1c000070, 32'h1c000170, 32'h1c000080, 32'h1c000180);
        apply_stimulus(0, 0, 1, 1, 32'h1c000090, 32'h1c000190, 3'b001, 0, '0, '0, '0);
        check("flush_count", {29'd0, q_count}, 0);
        check("flush_drops_kept", {27'd0, drop_cnt}, 2);
        idle(0); idle(0);

        // reset in the middle of a drain
        two(0, 32'h1c0000a0, 32'h1c0001a0, 32'h1c0000b0, 32'h1c0001b0);
        one(0, 32'h1c0000c0, 32'h1c0001c0, 3'b110);
        idle(0);
        apply_stimulus(1, 0, 0, 0, '0, '0, '0, 0, '0, '0, '0);
        check("rst_bm", {31'd0, branch_mistaken}, 0);
        check("rst_count", {29'd0, q_count}, 0);
        check("rst_drops", {27'd0, drop_cnt}, 0);
        idle(0); idle(0);

        // random traffic over a small PC pool so matches are frequent
        for (int n = 0; n < 600; n++) begin
            rr = ($urandom_range(0, 99) < 1);
            ff = ($urandom_range(0, 99) < 3);
            hh = ($urandom_range(0, 99) < 30);
            v0 = ($urandom_range(0, 99) < 55);
            v1 = ($urandom_range(0, 99) < 55);
            p0 = 32'h1c000000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            p1 = 32'h1c000000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            t0 = $urandom;
            t1 = $urandom;
            y0 = 3'($urandom_range(0, 7));
            y1 = 3'($urandom_range(0, 7));
            apply_stimulus(rr, hh, ff, v0, p0, t0, y0, v1, p1, t1, y1);
        end

        for (int n = 0; n < 8; n++) idle(0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
